// File: rtl/game_over.sv
// Score latch with a two-state RUN/OVER game FSM and a high-score register.
// latch_out follows the live score while running, freezes on game over,
// and high_score keeps the largest final score seen since reset.
module game_over (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  select,
  input  logic [31:0] binary_in,
  output logic [31:0] latch_out,
  output logic        over,
  output logic [31:0] high_score,
  output logic        new_record
);

  typedef enum logic [1:0] {
    SEL_RUN       = 2'b00,
    SEL_CAPTURE   = 2'b01,
    SEL_GAME_OVER = 2'b10,
    SEL_RESTART   = 2'b11
  } select_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_OVER = 1'b1
  } state_e;

  state_e      state, state_next;
  logic [31:0] latch_next;
  logic [31:0] high_next;
  logic        record_next;
  logic        end_game;
  logic [31:0] final_score;
  select_e     cmd;

  assign cmd = select_e'(select);

  // over is decoded straight from the state register, so it is registered too.
  assign over = (state == ST_OVER);

  // State register and all registered outputs; reset wins over any command.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    if (reset) begin
      state      <= ST_RUN;
      latch_out  <= '0;
      high_score <= '0;
      new_record <= 1'b0;
    end else begin
      state      <= state_next;
      latch_out  <= latch_next;
      high_score <= high_next;
      new_record <= record_next;
    end
  end

  // Next-state, next-latch and record detection for the current command.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch;
    // holding means "next equals current", and the pulse defaults low.
    state_next  = state;
    latch_next  = latch_out;
    high_next   = high_score;
    record_next = 1'b0;
    end_game    = 1'b0;
    final_score = latch_out;

    unique case (state)
      ST_RUN: begin
        unique case (cmd)
          SEL_RUN: begin
            latch_next = binary_in;
          end
          SEL_CAPTURE: begin
            // The captured live score becomes the final score.
            latch_next  = binary_in;
            final_score = binary_in;
            end_game    = 1'b1;
            state_next  = ST_OVER;
          end
          SEL_GAME_OVER: begin
            // Freeze on whatever was last latched.
            final_score = latch_out;
            end_game    = 1'b1;
            state_next  = ST_OVER;
          end
          SEL_RESTART: begin
            latch_next = '0;
          end
          default: ;
        endcase
      end
      ST_OVER: begin
        // Only restart leaves OVER; all other commands hold everything.
        if (cmd == SEL_RESTART) begin
          latch_next = '0;
          state_next = ST_RUN;
        end
      end
      default: ;
    endcase

    // Strictly greater: an equal score is not a new record.
    if (end_game && (final_score > high_score)) begin
      high_next   = final_score;
      record_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_game_over.sv
// Directed bench for game_over: reset, run/capture/game-over paths, record
// detection (greater, equal, less), restart, mid-cycle input changes, and
// reset priority while in OVER.
module tb_game_over;

  logic        clk;
  logic        reset;
  logic [1:0]  select;
  logic [31:0] binary_in;
  logic [31:0] latch_out;
  logic        over;
  logic [31:0] high_score;
  logic        new_record;

  int tests;
  int failed;

  game_over dut (
    .clk        (clk),
    .reset      (reset),
    .select     (select),
    .binary_in  (binary_in),
    .latch_out  (latch_out),
    .over       (over),
    .high_score (high_score),
    .new_record (new_record)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then sample 1 time unit after the rise.
  task automatic step(input logic [1:0] sel, input logic [31:0] bin);
    @(negedge clk);
    select    = sel;
    binary_in = bin;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] l, input logic o,
                           input logic [31:0] h, input logic n);
    check({tag, ".latch"}, latch_out, l);
    check({tag, ".over"}, {31'd0, over}, {31'd0, o});
    check({tag, ".high"}, high_score, h);
    check({tag, ".rec"}, {31'd0, new_record}, {31'd0, n});
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    reset     = 1'b1;
    select    = 2'b00;
    binary_in = 32'd0;

    // Reset state.
    step(2'b00, 32'd0);
    check_all("reset", 32'd0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;

    // Running: latch follows the live score.
    step(2'b00, 32'd55);
    check_all("run55", 32'd55, 1'b0, 32'd0, 1'b0);

    // Capture with a new record, then the pulse drops.
    step(2'b01, 32'd55);
    check_all("cap55", 32'd55, 1'b1, 32'd55, 1'b1);
    step(2'b10, 32'd22);
    check_all("over_hold", 32'd55, 1'b1, 32'd55, 1'b0);

    // In OVER, binary_in and non-restart commands have no effect.
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 32'd99);
      check_all("over_run99", 32'd55, 1'b1, 32'd55, 1'b0);
    end
    step(2'b01, 32'd77);
    check_all("over_cap77", 32'd55, 1'b1, 32'd55, 1'b0);

    // Restart from OVER, then a lower score via game-over: no record.
    step(2'b11, 32'd123);
    check_all("restart", 32'd0, 1'b0, 32'd55, 1'b0);
    step(2'b00, 32'd40);
    check_all("run40", 32'd40, 1'b0, 32'd55, 1'b0);
    step(2'b10, 32'd8);
    check_all("go40", 32'd40, 1'b1, 32'd55, 1'b0);

    // Equal final score does not update nor pulse.
    step(2'b11, 32'd0);
    step(2'b00, 32'd55);
    step(2'b10, 32'd1);
    check_all("go_equal", 32'd55, 1'b1, 32'd55, 1'b0);

    // Game-over path producing a record from the latched value.
    step(2'b11, 32'd0);
    step(2'b00, 32'd60);
    step(2'b10, 32'd3);
    check_all("go_rec60", 32'd60, 1'b1, 32'd60, 1'b1);

    // Restart from RUN clears latch and stays running.
    step(2'b11, 32'd0);
    step(2'b00, 32'd7);
    check_all("run7", 32'd7, 1'b0, 32'd60, 1'b0);
    step(2'b11, 32'd9);
    check_all("restart_run", 32'd0, 1'b0, 32'd60, 1'b0);

    // Mid-cycle input change is ignored until the next rising edge.
    step(2'b00, 32'd123);
    binary_in = 32'd456;
    select    = 2'b01;
    #2;
    check_all("midcycle", 32'd123, 1'b0, 32'd60, 1'b0);

    // Full-width capture record.
    step(2'b01, 32'hFFFF_FFFF);
    check_all("cap_max", 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step(2'b00, 32'd1);
    check_all("max_hold", 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // Reset takes priority over capture while in OVER.
    @(negedge clk);
    reset = 1'b1;
    step(2'b01, 32'd5);
    check_all("reset_over", 32'd0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    step(2'b00, 32'd9);
    check_all("post_reset", 32'd9, 1'b0, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
